// File: rtl/fighter_state_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_state_fsm
//  Description : Movement / attack state machine for one fighter character.
//                Button levels are synchronised, the attack button is edge
//                detected on clk, and the character state advances once per
//                video frame (frame_tick).  An attack runs three timed
//                phases: startup, active (hitbox on), recovery.
//
//  Parameters  : IS_MIRRORED      0 = right is forward, 1 = left is forward
//                STARTUP_FRAMES   frames in ATTACK_START    (1..63)
//                ACTIVE_FRAMES    frames in ATTACK_ACTIVE   (1..63)
//                RECOVERY_FRAMES  frames in ATTACK_RECOVERY (1..63)
//
//  Ports       : clk            system clock
//                rst_n          asynchronous active-low reset
//                frame_tick     one-clk pulse per video frame
//                btn_left       raw asynchronous button level
//                btn_right      raw asynchronous button level
//                btn_attack     raw asynchronous button level
//                state[2:0]     0 IDLE, 1 BACKWARD, 2 FORWARD, 3 ATTACK_START,
//                               4 ATTACK_ACTIVE, 5 ATTACK_RECOVERY
//                hitbox_active  high exactly while in ATTACK_ACTIVE
//                busy           high while in any attack state
//
//  Build macro : FIGHTER_ATTACK_BUFFER_EN
//                When defined, an attack press made during ATTACK_RECOVERY
//                is buffered and chains straight into a new ATTACK_START.
//
//  Revision    : 1.0  initial release
// ============================================================================

package fighter_state_pkg;
   typedef enum logic [2:0] {
      ST_IDLE            = 3'd0,
      ST_BACKWARD        = 3'd1,
      ST_FORWARD         = 3'd2,
      ST_ATTACK_START    = 3'd3,
      ST_ATTACK_ACTIVE   = 3'd4,
      ST_ATTACK_RECOVERY = 3'd5
   } state_t;
endpackage

module fighter_state_fsm
   import fighter_state_pkg::*;
#(
   parameter int IS_MIRRORED     = 0,
   parameter int STARTUP_FRAMES  = 4,
   parameter int ACTIVE_FRAMES   = 3,
   parameter int RECOVERY_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   output logic [2:0] state,
   output logic       hitbox_active,
   output logic       busy
);

   // Counter reload values: a phase of N frames counts N-1 down to 0.
   localparam logic [5:0] c_STARTUP_LOAD  = 6'(STARTUP_FRAMES - 1);
   localparam logic [5:0] c_ACTIVE_LOAD   = 6'(ACTIVE_FRAMES - 1);
   localparam logic [5:0] c_RECOVERY_LOAD = 6'(RECOVERY_FRAMES - 1);

`ifdef FIGHTER_ATTACK_BUFFER_EN
   localparam bit c_BUFFER_EN = 1'b1;
`else
   localparam bit c_BUFFER_EN = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Button synchronisers.  Bit order: [0] left, [1] right, [2] attack.
   // ------------------------------------------------------------------
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic       r_attack_prev;
   // r_sync_valid fills with ones after reset; once bit 1 is set, r_sync2
   // carries a genuine sample instead of the reset zero.
   logic [1:0] r_sync_valid;
   // Armed only after a genuine "attack released" sample has been seen,
   // so a button held through reset release never looks like a press.
   logic       r_attack_armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1        <= 3'b000;
         r_sync2        <= 3'b000;
         r_attack_prev  <= 1'b0;
         r_sync_valid   <= 2'b00;
         r_attack_armed <= 1'b0;
      end else begin
         r_sync1       <= {btn_attack, btn_right, btn_left};
         r_sync2       <= r_sync1;
         r_attack_prev <= r_sync2[2];
         r_sync_valid  <= {r_sync_valid[0], 1'b1};
         if (r_sync_valid[1] && !r_sync2[2]) begin
            r_attack_armed <= 1'b1;
         end
      end
   end

   logic w_attack_rise;
   assign w_attack_rise = r_attack_armed && r_sync2[2] && !r_attack_prev;

   // ------------------------------------------------------------------
   // Direction decode
   // ------------------------------------------------------------------
   logic   w_fwd_held;
   logic   w_bwd_held;
   state_t w_dir_state;

   assign w_fwd_held = (IS_MIRRORED != 0) ? r_sync2[0] : r_sync2[1];
   assign w_bwd_held = (IS_MIRRORED != 0) ? r_sync2[1] : r_sync2[0];

   always_comb begin
      w_dir_state = ST_IDLE;
      if (w_fwd_held && !w_bwd_held) begin
         w_dir_state = ST_FORWARD;
      end else if (w_bwd_held && !w_fwd_held) begin
         w_dir_state = ST_BACKWARD;
      end
   end

   // ------------------------------------------------------------------
   // Main state machine
   // ------------------------------------------------------------------
   state_t     r_state;
   logic [5:0] r_count;
   logic       r_hitbox;
   logic       r_busy;
   logic       r_attack_pending;

   logic w_in_move;
   logic w_in_attack;
   logic w_recovery_last;
   logic w_enter_start;
   logic w_hold_pending;
   logic w_pending_clear;

   assign w_in_move   = (r_state == ST_IDLE) || (r_state == ST_BACKWARD) ||
                        (r_state == ST_FORWARD);
   assign w_in_attack = (r_state == ST_ATTACK_START) ||
                        (r_state == ST_ATTACK_ACTIVE) ||
                        (r_state == ST_ATTACK_RECOVERY);
   assign w_recovery_last = (r_state == ST_ATTACK_RECOVERY) && (r_count == 6'd0);

   // The tick is about to start an attack, either from a movement state or
   // by chaining out of the final recovery frame when buffering is built in.
   assign w_enter_start = r_attack_pending &&
                          (w_in_move || (c_BUFFER_EN && w_recovery_last));
   // With buffering, presses caught during recovery survive recovery ticks.
   assign w_hold_pending  = c_BUFFER_EN && (r_state == ST_ATTACK_RECOVERY);
   assign w_pending_clear = frame_tick &&
                            (w_enter_start || (w_in_attack && !w_hold_pending));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_count          <= 6'd0;
         r_hitbox         <= 1'b0;
         r_busy           <= 1'b0;
         r_attack_pending <= 1'b0;
      end else begin
         // A fresh edge takes priority over a clear in the same cycle, so a
         // press landing exactly on a tick is never silently lost.
         if (w_pending_clear) begin
            r_attack_pending <= 1'b0;
         end
         if (w_attack_rise) begin
            r_attack_pending <= 1'b1;
         end

         if (frame_tick) begin
            case (r_state)
               ST_IDLE, ST_BACKWARD, ST_FORWARD: begin
                  r_hitbox <= 1'b0;
                  if (r_attack_pending) begin
                     r_state <= ST_ATTACK_START;
                     r_count <= c_STARTUP_LOAD;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= w_dir_state;
                     r_busy  <= 1'b0;
                  end
               end

               ST_ATTACK_START: begin
                  if (r_count == 6'd0) begin
                     r_state  <= ST_ATTACK_ACTIVE;
                     r_count  <= c_ACTIVE_LOAD;
                     r_hitbox <= 1'b1;
                     r_busy   <= 1'b1;
                  end else begin
                     r_count <= r_count - 6'd1;
                  end
               end

               ST_ATTACK_ACTIVE: begin
                  if (r_count == 6'd0) begin
                     r_state  <= ST_ATTACK_RECOVERY;
                     r_count  <= c_RECOVERY_LOAD;
                     r_hitbox <= 1'b0;
                     r_busy   <= 1'b1;
                  end else begin
                     r_count <= r_count - 6'd1;
                  end
               end

               ST_ATTACK_RECOVERY: begin
                  if (r_count == 6'd0) begin
                     r_hitbox <= 1'b0;
                     if (c_BUFFER_EN && r_attack_pending) begin
                        r_state <= ST_ATTACK_START;
                        r_count <= c_STARTUP_LOAD;
                        r_busy  <= 1'b1;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_count <= r_count - 6'd1;
                  end
               end

               // Encodings 6 and 7 are unreachable; recover to IDLE.
               default: begin
                  r_state  <= ST_IDLE;
                  r_count  <= 6'd0;
                  r_hitbox <= 1'b0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state         = r_state;
   assign hitbox_active = r_hitbox;
   assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fighter_state_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fighter_state_fsm
//  Description : Self-checking bench for fighter_state_fsm.  Drives a normal
//                and a mirrored instance from the same buttons and compares
//                both against a frame-level reference model, plus table and
//                hand-written expectations for the documented scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fighter_state_fsm;
   import fighter_state_pkg::*;

   localparam int S     = 4;
   localparam int A     = 3;
   localparam int R     = 8;
   localparam int TOTAL = S + A + R;
`ifdef FIGHTER_ATTACK_BUFFER_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_attack = 1'b0;
   logic [2:0] state0, state1;
   logic       hit0, hit1, busy0, busy1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fighter_state_fsm #(.IS_MIRRORED(0), .STARTUP_FRAMES(S), .ACTIVE_FRAMES(A),
                       .RECOVERY_FRAMES(R)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
      .state(state0), .hitbox_active(hit0), .busy(busy0));

   fighter_state_fsm #(.IS_MIRRORED(1), .STARTUP_FRAMES(S), .ACTIVE_FRAMES(A),
                       .RECOVERY_FRAMES(R)) dut_m (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
      .state(state1), .hitbox_active(hit1), .busy(busy1));

   // ---------------- reference model (frame level) ----------------
   logic [2:0] hist[$];   // every sampled {attack,right,left} since reset
   bit         m_pend;
   bit         m_att;     // an attack is in progress
   int         m_frame;   // ticks elapsed since the attack started
   bit         m_bad0;    // instance 0 forced into an unused encoding
   logic [2:0] m_idle[2]; // movement state per instance when not attacking

   function automatic logic [2:0] phase(int f);
      if (f < S)     return 3'd3;
      if (f < S + A) return 3'd4;
      return 3'd5;
   endfunction

   function automatic logic [2:0] dir_map(logic [2:0] s, bit mir);
      bit fwd;
      bit bwd;
      fwd = mir ? s[0] : s[1];
      bwd = mir ? s[1] : s[0];
      if (fwd && !bwd) return 3'd2;
      if (bwd && !fwd) return 3'd1;
      return 3'd0;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_pend  = 0;
      m_att   = 0;
      m_frame = 0;
      m_bad0  = 0;
      m_idle[0] = 3'd0;
      m_idle[1] = 3'd0;
   endtask

   // Buttons are seen two clocks late; a press is a sampled 0 followed by 1.
   task automatic model_clk();
      int         n;
      bit         edge_seen;
      bit         enter;
      bit         clr;
      logic [2:0] syn;
      if (!rst_n) begin
         model_reset();
      end else begin
         hist.push_back({btn_attack, btn_right, btn_left});
         n = hist.size();
         edge_seen = (n >= 4) && !hist[n-4][2] && hist[n-3][2];
         syn = (n >= 3) ? hist[n-3] : 3'b000;
         if (frame_tick) begin
            enter = 0;
            clr   = 0;
            if (m_att) begin
               clr = !(BUF && phase(m_frame) == 3'd5);
               m_frame++;
               if (m_frame == TOTAL) begin
                  if (BUF && m_pend) begin
                     m_frame = 0;
                     enter   = 1;
                  end else begin
                     m_att     = 0;
                     m_idle[0] = 3'd0;
                     m_idle[1] = 3'd0;
                  end
               end
            end else if (m_bad0) begin
               m_bad0    = 0;
               m_idle[0] = 3'd0;
               m_idle[1] = dir_map(syn, 1'b1);
            end else if (m_pend) begin
               m_att   = 1;
               m_frame = 0;
               enter   = 1;
            end else begin
               m_idle[0] = dir_map(syn, 1'b0);
               m_idle[1] = dir_map(syn, 1'b1);
            end
            if (enter) clr = 1;
            if (clr) m_pend = 0;
         end
         if (edge_seen) m_pend = 1;
      end
   endtask

   function automatic logic [4:0] exp_out(int i);
      logic [2:0] s;
      if (m_att)                s = phase(m_frame);
      else if (i == 0 && m_bad0) s = 3'd7;
      else                      s = m_idle[i];
      return {s, m_att, (m_att && s == 3'd4)};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d busy=%b hit=%b, want state=%0d busy=%b hit=%b",
                  name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic step(input bit t, input bit l, input bit r, input bit a);
      frame_tick = t;
      btn_left   = l;
      btn_right  = r;
      btn_attack = a;
      @(posedge clk);
      model_clk();
      @(negedge clk);
      check("model_n", {state0, busy0, hit0}, exp_out(0));
      check("model_m", {state1, busy1, hit1}, exp_out(1));
   endtask

   task automatic flush_frames(input int nf);
      for (int k = 0; k < nf; k++) begin
         step(1, 0, 0, 0);
         step(0, 0, 0, 0);
         step(0, 0, 0, 0);
      end
   endtask

   typedef struct {
      bit         l;
      bit         r;
      logic [2:0] exp0;
      logic [2:0] exp1;
   } dir_vec_t;

   dir_vec_t   vec[8];
   logic [2:0] exp_s;
   bit         rl, rr, ra;

   initial begin
      vec[0] = '{1'b0, 1'b0, 3'd0, 3'd0};
      vec[1] = '{1'b0, 1'b1, 3'd2, 3'd1};
      vec[2] = '{1'b0, 1'b1, 3'd2, 3'd1};
      vec[3] = '{1'b0, 1'b1, 3'd2, 3'd1};
      vec[4] = '{1'b0, 1'b0, 3'd0, 3'd0};
      vec[5] = '{1'b1, 1'b0, 3'd1, 3'd2};
      vec[6] = '{1'b1, 1'b1, 3'd0, 3'd0};
      vec[7] = '{1'b1, 1'b0, 3'd1, 3'd2};

      model_reset();
      @(negedge clk);
      repeat (3) step(0, 0, 0, 0);
      check("reset_n", {state0, busy0, hit0}, 5'b0);
      check("reset_m", {state1, busy1, hit1}, 5'b0);
      rst_n = 1'b1;
      repeat (4) step(0, 0, 0, 0);

      // Direction table: hold buttons, then one tick.
      for (int i = 0; i < 8; i++) begin
         repeat (3) step(0, vec[i].l, vec[i].r, 0);
         step(1, vec[i].l, vec[i].r, 0);
         check($sformatf("dir%0d_n", i), {state0, busy0, hit0}, {vec[i].exp0, 2'b00});
         check($sformatf("dir%0d_m", i), {state1, busy1, hit1}, {vec[i].exp1, 2'b00});
      end
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);

      // Full attack from a 5-clk pulse; left toggled while busy is ignored.
      repeat (5) step(0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0);
      for (int k = 1; k <= TOTAL + 1; k++) begin
         rl = (k >= 2 && k <= 10) ? k[0] : 1'b0;
         step(1, rl, 0, 0);
         exp_s = (k <= S) ? 3'd3 : (k <= S + A) ? 3'd4 : (k <= TOTAL) ? 3'd5 : 3'd0;
         check($sformatf("atk_t%0d", k), {state0, busy0, hit0},
               {exp_s, exp_s >= 3'd3, exp_s == 3'd4});
         check($sformatf("atk_m_t%0d", k), {state1, busy1, hit1},
               {exp_s, exp_s >= 3'd3, exp_s == 3'd4});
         step(0, rl, 0, 0);
         step(0, 0, 0, 0);
      end

      // Press during the third recovery frame.
      repeat (3) step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      for (int k = 1; k <= TOTAL + 2; k++) begin
         step(1, 0, 0, 0);
         if (k == TOTAL + 1)
            check("rec_press_end", {state0, busy0, hit0}, BUF ? 5'b011_1_0 : 5'b000_0_0);
         if (k == TOTAL + 2)
            check("rec_press_next", {state0, busy0, hit0}, BUF ? 5'b011_1_0 : 5'b000_0_0);
         if (k == S + A + 3) begin
            repeat (3) step(0, 0, 0, 1);
            repeat (3) step(0, 0, 0, 0);
         end else begin
            repeat (2) step(0, 0, 0, 0);
         end
      end
      flush_frames(TOTAL + 2);

      // Reset mid-active with attack held, then no attack until re-pressed.
      repeat (4) step(0, 0, 0, 1);
      for (int k = 1; k <= S + 1; k++) begin
         step(1, 0, 0, 1);
         repeat (2) step(0, 0, 0, 1);
      end
      check("pre_reset_active", {state0, busy0, hit0}, 5'b100_1_1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset", {state0, busy0, hit0}, 5'b0);
      repeat (2) step(0, 0, 0, 1);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step(1, 0, 0, 1);
         check($sformatf("held_no_atk%0d", k), {state0, busy0, hit0}, 5'b0);
         repeat (2) step(0, 0, 0, 1);
      end
      repeat (4) step(0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      check("repress_attack", {state0, busy0, hit0}, 5'b011_1_0);
      flush_frames(TOTAL + 1);

      // Unused encoding recovers to IDLE on the next tick.
      force dut.r_state = state_t'(3'd7);
      m_bad0 = 1;
      step(0, 0, 0, 0);
      release dut.r_state;
      step(1, 0, 0, 0);
      check("bad_state_recover", {state0, busy0, hit0}, 5'b0);

      // Randomised run against the model.
      rl = 0; rr = 0; ra = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) rl = ~rl;
         if ($urandom_range(0, 9) == 0) rr = ~rr;
         if ($urandom_range(0, 5) == 0) ra = ~ra;
         step($urandom_range(0, 3) == 0, rl, rr, ra);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
